lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Load/store unit on the CPU side of the data-memory port: the initiator that drives mrd/mwr/adr/d_in/data_out_mask.
//  Accepts one load/store per handshake from the execute stage, checks alignment, drives a word-aligned access with lane mask,
//  extracts/sign-extends load data and returns it, or raises a misaligned/illegal trap to the trap unit without touching memory.
// PARAMETERS
//  MEM_LATENCY  0  extra cycles to wait after the first access cycle before sampling d_out (0 = combinational read)
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  req_valid      in   1   execute stage presents a memory op
//  req_ready      out  1   LSU idle, request accepted on clk edge when req_valid&req_ready
//  req_load       in   1   op is a load
//  req_store      in   1   op is a store
//  req_funct3     in   3   RV32I funct3 (LB 000 LH 001 LW 010 LBU 100 LHU 101; SB 000 SH 001 SW 010)
//  req_addr       in   32  effective byte address
//  req_wdata      in   32  store data (rs2)
//  resp_valid     out  1   one-cycle pulse: op completed OK
//  resp_rdata     out  32  load result, extended; 0 for stores; held until next resp_valid
//  exc_valid      out  1   one-cycle pulse: op trapped
//  exc_cause      out  4   4 load-misaligned, 6 store-misaligned, 2 illegal
//  exc_tval       out  32  faulting req_addr (0 for illegal)
//  mrd            out  1   memory read enable
//  mwr            out  1   memory write enable
//  adr            out  32  {addr[31:2],2'b00}
//  d_in           out  32  store data replicated to lanes
//  data_out_mask  out  4   byte-lane mask
//  d_out          in   32  memory read word
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid, exc_valid, mrd, mwr=0; adr, d_in, resp_rdata, exc_tval=0; mask=0000; exc_cause=0.
//  FSM IDLE -> ACCESS | TRAP; ACCESS -> ACCESS (count>0) | RESP; RESP -> IDLE; TRAP -> IDLE.
//  IDLE: req_ready=1. Accept latches addr, wdata, funct3, kind. Go TRAP if: load&store both set, or neither,
//   or funct3 not legal for kind (cause 2); LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 (cause 4 load/6 store).
//   Otherwise go ACCESS, counter=MEM_LATENCY.
//  ACCESS: req_ready=0. adr, mask, d_in stable for whole state. Load: mrd=1 every ACCESS cycle.
//   Store: mwr=1 only on first ACCESS cycle (exactly one write edge).
//   count==0: load captures d_out into resp_rdata, go RESP; else count--.
//  Mask by o=addr[1:0]: byte 1<<o; half o=0 -> 0011, o=2 -> 1100; word 1111. Same mask driven for loads.
//  d_in: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
//  Load extract: byte = d_out[8*o+7:8*o], half = d_out[16*o[1]+15:16*o[1]]; LB/LH sign-extend, LBU/LHU zero-extend.
//  RESP: resp_valid=1 one cycle, mrd/mwr=0. TRAP: exc_valid=1 one cycle, exc_tval set; mrd/mwr never asserted.
//  Latency (MEM_LATENCY=0): accept edge N, ACCESS cycle N+1, resp_valid cycle N+2; +MEM_LATENCY per wait.
//  Trap latency: exc_valid in cycle N+1. Back-to-back: next accept earliest in the resp/exc cycle's following IDLE cycle.
//  req_valid while req_ready=0: ignored, not queued. resp_valid and exc_valid never both 1.
//  rst_n low mid-op: immediate IDLE, mrd/mwr drop asynchronously, op discarded, no resp/exc.
// TESTING
//  SW addr=0x1004 wdata=0xDEADBEEF -> one mwr cycle, adr=0x1004 mask=1111; then LW 0x1004 -> resp_rdata=0xDEADBEEF at N+2.
//  SB addr=0x1007 wdata=0x80 -> mask=1000 d_in=0x80808080; LB 0x1007 -> 0xFFFFFF80; LBU 0x1007 -> 0x00000080.
//  SH addr=0x1002 wdata=0x8001 -> mask=1100; LH 0x1002 -> 0xFFFF8001; LHU -> 0x00008001.
//  LW 0x1001 -> exc_valid, cause 4, tval 0x1001, mrd never high; SH 0x1003 -> cause 6, mwr never high.
//  Load funct3=011 -> cause 2, tval 0; MEM_LATENCY=2 LW -> mrd high 3 cycles, resp at N+4; req_valid while busy ignored.
//  rst_n asserted during ACCESS with mwr=1 -> mwr=0 immediately, req_ready=1 after release, no resp_valid.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit driving the data-memory port with alignment checks and load extension
module lsu_mem_master #(
   parameter int MEM_LATENCY = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        exc_valid,
   output logic [3:0]  exc_cause,
   output logic [31:0] exc_tval,
   output logic        mrd,
   output logic        mwr,
   output logic [31:0] adr,
   output logic [31:0] d_in,
   output logic [3:0]  data_out_mask,
   input  logic [31:0] d_out
);
   localparam int CW = MEM_LATENCY > 0 ? $clog2(MEM_LATENCY + 1) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP, TRAP} state_t;
   state_t state;
   logic [CW-1:0] count;
   logic [1:0] off_q;
   logic [2:0] f3_q;
   logic load_q, legal, misal;
   logic [3:0] mask_c;
   logic [31:0] wdata_c, rdata_c;
   logic [15:0] lane;
   // Classify the presented request and build its lane mask and replicated store data
   always_comb begin
      legal = (req_load ^ req_store) && (req_load ? (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                                  : (req_funct3 inside {3'b000, 3'b001, 3'b010}));
      misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      mask_c = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
               req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_c = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
   end
   // Pick the addressed byte/halfword out of the read word and sign- or zero-extend it
   always_comb begin
      lane = 16'(d_out >> {off_q, 3'b000});
      rdata_c = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane} : d_out;
   end
   // Request FSM: accept, access memory for 1+MEM_LATENCY cycles, then pulse response or trap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         req_ready <= 1'b1;
         resp_valid <= 1'b0;
         exc_valid <= 1'b0;
         mrd <= 1'b0;
         mwr <= 1'b0;
         adr <= '0;
         d_in <= '0;
         data_out_mask <= '0;
         resp_rdata <= '0;
         exc_cause <= '0;
         exc_tval <= '0;
         count <= '0;
         off_q <= '0;
         f3_q <= '0;
         load_q <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         exc_valid <= 1'b0;
         mwr <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               if (!legal || misal) begin
                  state <= TRAP;
                  exc_valid <= 1'b1;
                  exc_cause <= !legal ? 4'd2 : req_load ? 4'd4 : 4'd6;
                  exc_tval <= legal ? req_addr : 32'd0;
               end else begin
                  state <= ACCESS;
                  count <= CW'(MEM_LATENCY);
                  off_q <= req_addr[1:0];
                  f3_q <= req_funct3;
                  load_q <= req_load;
                  mrd <= req_load;
                  mwr <= req_store;
                  adr <= {req_addr[31:2], 2'b00};
                  data_out_mask <= mask_c;
                  d_in <= wdata_c;
               end
            end
            ACCESS: if (count == '0) begin
               state <= RESP;
               mrd <= 1'b0;
               resp_valid <= 1'b1;
               resp_rdata <= load_q ? rdata_c : 32'd0;
            end else begin
               count <= count - CW'(1);
            end
            default: begin
               state <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: randomized and directed check of lsu_mem_master against a byte-level memory model
module tb_lsu_mem_master;
   localparam int LAT1 = 2;
   typedef struct {
      logic ready, rv, ev, mrd, mwr, bus, din_chk;
      logic [31:0] adr, din, rdata, tval;
      logic [3:0] mask, cause;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n;
   logic req_valid [2];
   logic req_load, req_store;
   logic [2:0] req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic req_ready [2], resp_valid [2], exc_valid [2], mrd [2], mwr [2];
   logic [31:0] resp_rdata [2], exc_tval [2], adr [2], d_in [2], d_out [2];
   logic [3:0] exc_cause [2], data_out_mask [2];
   logic [31:0] mem [2][16];
   logic [7:0] refb [2][64];
   exp_t exp [2];
   logic chk_en = 1'b0;
   int n_chk = 0, n_err = 0;
   int nrd, nwr, resp_at, exc_at;
   logic got_bus;
   logic [31:0] obs_adr, obs_din;
   logic [3:0] obs_mask;

   always #5 clk = ~clk;

   lsu_mem_master #(.MEM_LATENCY(0)) u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
      .exc_valid(exc_valid[0]), .exc_cause(exc_cause[0]), .exc_tval(exc_tval[0]),
      .mrd(mrd[0]), .mwr(mwr[0]), .adr(adr[0]), .d_in(d_in[0]),
      .data_out_mask(data_out_mask[0]), .d_out(d_out[0]));
   lsu_mem_master #(.MEM_LATENCY(LAT1)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
      .exc_valid(exc_valid[1]), .exc_cause(exc_cause[1]), .exc_tval(exc_tval[1]),
      .mrd(mrd[1]), .mwr(mwr[1]), .adr(adr[1]), .d_in(d_in[1]),
      .data_out_mask(data_out_mask[1]), .d_out(d_out[1]));

   assign d_out[0] = mem[0][adr[0][5:2]];
   assign d_out[1] = mem[1][adr[1][5:2]];

   // memory device: reloaded from the reference bytes while in reset, byte-masked writes otherwise
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int w = 0; w < 16; w++)
               mem[k][w] <= {refb[k][4*w+3], refb[k][4*w+2], refb[k][4*w+1], refb[k][4*w]};
         end else if (mwr[k]) begin
            for (int i = 0; i < 4; i++)
               if (data_out_mask[k][i]) mem[k][adr[k][5:2]][8*i +: 8] <= d_in[k][8*i +: 8];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, expv);
      end
   endtask

   // per-cycle compare of both DUTs against the model's expected outputs
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k), 32'(req_ready[k]), 32'(exp[k].ready));
            chk($sformatf("resp_valid%0d", k), 32'(resp_valid[k]), 32'(exp[k].rv));
            chk($sformatf("exc_valid%0d", k), 32'(exc_valid[k]), 32'(exp[k].ev));
            chk($sformatf("mrd%0d", k), 32'(mrd[k]), 32'(exp[k].mrd));
            chk($sformatf("mwr%0d", k), 32'(mwr[k]), 32'(exp[k].mwr));
            chk($sformatf("resp_rdata%0d", k), resp_rdata[k], exp[k].rdata);
            chk($sformatf("exc_cause%0d", k), 32'(exc_cause[k]), 32'(exp[k].cause));
            chk($sformatf("exc_tval%0d", k), exc_tval[k], exp[k].tval);
            if (exp[k].bus) begin
               chk($sformatf("adr%0d", k), adr[k], exp[k].adr);
               chk($sformatf("mask%0d", k), 32'(data_out_mask[k]), 32'(exp[k].mask));
            end
            if (exp[k].din_chk) chk($sformatf("d_in%0d", k), d_in[k], exp[k].din);
         end
      end
   end

   task automatic set_idle(input int k);
      exp[k].ready = 1'b1; exp[k].rv = 1'b0; exp[k].ev = 1'b0;
      exp[k].mrd = 1'b0; exp[k].mwr = 1'b0; exp[k].bus = 1'b0; exp[k].din_chk = 1'b0;
   endtask

   task automatic noise(input int k);
      req_valid[k] = 1'($urandom % 2);
      req_load = 1'($urandom % 2);
      req_store = 1'($urandom % 2);
      req_funct3 = 3'($urandom % 8);
      req_addr = $urandom;
      req_wdata = $urandom;
   endtask

   task automatic sample(input int k, input int cyc);
      if (mrd[k]) nrd++;
      if (mwr[k]) nwr++;
      if ((mrd[k] || mwr[k]) && !got_bus) begin
         got_bus = 1'b1; obs_adr = adr[k]; obs_mask = data_out_mask[k]; obs_din = d_in[k];
      end
      if (resp_valid[k] && resp_at < 0) resp_at = cyc;
      if (exc_valid[k] && exc_at < 0) exc_at = cyc;
   endtask

   task automatic do_op(input int k, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic busy_noise);
      int size, b, lat, cyc;
      logic ill, mis;
      logic [3:0] m;
      logic [31:0] din, val;
      lat = k == 0 ? 0 : LAT1;
      ill = (ld == st) || (ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2}));
      size = 1 << f3[1:0];
      mis = !ill && (a % size != 0);
      b = int'(a % 64);
      m = 4'(((1 << size) - 1) << (a % 4));
      din = 0;
      for (int i = 0; i < 4; i++) din[8*i +: 8] = wd[8*(i % size) +: 8];
      val = 0;
      if (!ill && !mis && ld) begin
         for (int i = 0; i < size; i++) val = val | (32'(refb[k][b+i]) << (8*i));
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 1);
      end
      if (!ill && !mis && st)
         for (int i = 0; i < size; i++) refb[k][b+i] = wd[8*i +: 8];
      nrd = 0; nwr = 0; resp_at = -1; exc_at = -1; got_bus = 1'b0;
      req_load = ld; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid[k] = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      if (ill || mis) begin
         exp[k].ready = 1'b0; exp[k].ev = 1'b1;
         exp[k].cause = ill ? 4'd2 : ld ? 4'd4 : 4'd6;
         exp[k].tval = ill ? 32'd0 : a;
         if (busy_noise) noise(k); else req_valid[k] = 1'b0;
         sample(k, cyc);
         @(posedge clk); #1;
         cyc++;
      end else begin
         for (int s = 0; s <= lat + 1; s++) begin
            exp[k].ready = 1'b0;
            if (s <= lat) begin
               exp[k].mrd = ld; exp[k].mwr = st && s == 0; exp[k].bus = 1'b1;
               exp[k].adr = a & ~32'd3; exp[k].mask = m; exp[k].din = din; exp[k].din_chk = st;
            end else begin
               exp[k].mrd = 1'b0; exp[k].mwr = 1'b0; exp[k].bus = 1'b0; exp[k].din_chk = 1'b0;
               exp[k].rv = 1'b1; exp[k].rdata = ld ? val : 32'd0;
            end
            if (busy_noise) noise(k); else req_valid[k] = 1'b0;
            sample(k, cyc);
            @(posedge clk); #1;
            cyc++;
         end
      end
      req_valid[k] = 1'b0;
      set_idle(k);
      sample(k, cyc);
   endtask

   initial begin
      int k, off, size;
      logic ld, st;
      logic [2:0] f3;
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < 64; i++) refb[j][i] = 8'($urandom);
         req_valid[j] = 1'b0;
         exp[j] = '{ready: 1'b1, rv: 1'b0, ev: 1'b0, mrd: 1'b0, mwr: 1'b0, bus: 1'b1, din_chk: 1'b1,
                    adr: 32'd0, din: 32'd0, rdata: 32'd0, tval: 32'd0, mask: 4'd0, cause: 4'd0};
      end
      req_load = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      set_idle(0); set_idle(1);
      @(posedge clk); #1;
      // directed on the zero-latency unit
      do_op(0, 1'b0, 1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, 1'b0);
      chk("sw_nwr", 32'(nwr), 32'd1);
      chk("sw_adr", obs_adr, 32'h1004);
      chk("sw_mask", 32'(obs_mask), 32'hF);
      do_op(0, 1'b1, 1'b0, 3'b010, 32'h1004, 32'h0, 1'b1);
      chk("lw_resp_at", 32'(resp_at), 32'd2);
      chk("lw_data", resp_rdata[0], 32'hDEADBEEF);
      do_op(0, 1'b0, 1'b1, 3'b000, 32'h1007, 32'h80, 1'b0);
      chk("sb_mask", 32'(obs_mask), 32'h8);
      chk("sb_din", obs_din, 32'h80808080);
      do_op(0, 1'b1, 1'b0, 3'b000, 32'h1007, 32'h0, 1'b0);
      chk("lb_data", resp_rdata[0], 32'hFFFFFF80);
      do_op(0, 1'b1, 1'b0, 3'b100, 32'h1007, 32'h0, 1'b0);
      chk("lbu_data", resp_rdata[0], 32'h00000080);
      do_op(0, 1'b0, 1'b1, 3'b001, 32'h1002, 32'h8001, 1'b0);
      chk("sh_mask", 32'(obs_mask), 32'hC);
      do_op(0, 1'b1, 1'b0, 3'b001, 32'h1002, 32'h0, 1'b0);
      chk("lh_data", resp_rdata[0], 32'hFFFF8001);
      do_op(0, 1'b1, 1'b0, 3'b101, 32'h1002, 32'h0, 1'b0);
      chk("lhu_data", resp_rdata[0], 32'h00008001);
      do_op(0, 1'b1, 1'b0, 3'b010, 32'h1001, 32'h0, 1'b1);
      chk("lw_mis_cause", 32'(exc_cause[0]), 32'd4);
      chk("lw_mis_tval", exc_tval[0], 32'h1001);
      chk("lw_mis_exc_at", 32'(exc_at), 32'd1);
      chk("lw_mis_nrd", 32'(nrd), 32'd0);
      do_op(0, 1'b0, 1'b1, 3'b001, 32'h1003, 32'h1234, 1'b0);
      chk("sh_mis_cause", 32'(exc_cause[0]), 32'd6);
      chk("sh_mis_nwr", 32'(nwr), 32'd0);
      do_op(0, 1'b1, 1'b0, 3'b011, 32'h1008, 32'h0, 1'b0);
      chk("ill_cause", 32'(exc_cause[0]), 32'd2);
      chk("ill_tval", exc_tval[0], 32'd0);
      // directed on the latency-2 unit
      do_op(1, 1'b0, 1'b1, 3'b010, 32'h2010, 32'h0BADF00D, 1'b1);
      chk("l2_sw_nwr", 32'(nwr), 32'd1);
      do_op(1, 1'b1, 1'b0, 3'b010, 32'h2010, 32'h0, 1'b1);
      chk("l2_lw_nrd", 32'(nrd), 32'd3);
      chk("l2_lw_resp_at", 32'(resp_at), 32'd4);
      chk("l2_lw_data", resp_rdata[1], 32'h0BADF00D);
      // reset while a store is writing
      req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1008; req_wdata = 32'h55AA55AA;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk("rst_pre_mwr", 32'(mwr[0]), 32'd1);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("rst_mwr_drop", 32'(mwr[0]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int j = 0; j < 2; j++) begin
         set_idle(j);
         exp[j].rdata = 32'd0; exp[j].cause = 4'd0; exp[j].tval = 32'd0;
      end
      chk_en = 1'b1;
      resp_at = -1;
      for (int c = 0; c < 3; c++) begin
         sample(0, c);
         @(posedge clk); #1;
      end
      chk("rst_no_resp", 32'(resp_at), 32'hFFFFFFFF);
      chk("rst_ready", 32'(req_ready[0]), 32'd1);
      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         k = int'($urandom % 2);
         if ($urandom % 16 == 0) begin
            ld = 1'($urandom % 2); st = ld;
         end else begin
            ld = 1'($urandom % 2); st = !ld;
         end
         if ($urandom % 10 == 0) f3 = 3'($urandom % 8);
         else if (ld) begin
            f3 = 3'($urandom % 5);
            if (f3 > 3'd2) f3 = f3 + 3'd1;
         end else f3 = 3'($urandom % 3);
         size = 1 << f3[1:0];
         off = int'($urandom % 64);
         if ($urandom % 4 != 0) off = off & ~(size - 1);
         do_op(k, ld, st, f3, ($urandom & ~32'd63) | 32'(off), $urandom, 1'($urandom % 2));
         if ($urandom % 4 == 0) begin
            @(posedge clk); #1;
         end
      end
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
